arcade_input_map: RTL and testbench
===================================

# arcade_input_map

Parametrised keyboard/joystick-to-cabinet-button mapper for arcade cores: decodes `ps2_key` events through a runtime-loadable scancode map, holds per-player pressed state, merges HPS joysticks, and applies optional 90° direction remap for rotated screens. It sits between `hps_io` and the game core, generalising the per-core hard-coded `casex` key decode to N players and a ROM-loaded key table. It also provides an optional auto-coin pulse.

## Interface
- `PLAYERS`, 2, number of players (1–4)
- `MAP_DEPTH`, 32, map entries (power of 2, 8–256)
- `COIN_PULSE`, 16'd2048, auto-coin pulse length in `clk_sys` cycles (≥1)

- `clk_sys`  in  1  system clock
- `reset_n`  in  1  asynchronous, active-low reset
- `ps2_key`  in  11  [10] event toggle, [9] pressed, [8:0] code ([8] = extended)
- `joystick`  in  16*PLAYERS  player p at [16p+15:16p]
- `rotate`  in  1  1 = apply direction remap
- `map_wr`  in  1  map write strobe
- `map_addr`  in  $clog2(MAP_DEPTH)  entry index
- `map_data`  in  16  [8:0] code, [9] ext-wildcard, [11:10] player, [14:12] button, [15] valid
- `btn`  out  8*PLAYERS  per player: 0 right, 1 left, 2 down, 3 up, 4 fire, 5 fire2, 6 start, 7 coin
- `busy`  out  1  init sweep or scan in progress
- `overflow`  out  1  sticky: key event dropped

## Operation
- States: INIT, IDLE, SCAN.
- INIT: entered on reset release. Writes valid=0 to entries 0..MAP_DEPTH-1, one per cycle. `map_wr` is ignored during INIT. Then goes to IDLE.
- Event detection: `ps2_key[10]` is registered; a change of the registered value is one event. Event code and pressed are captured.
- IDLE + event: go to SCAN at index 0.
- SCAN: reads one entry per cycle from synchronous RAM, index 0..MAP_DEPTH-1.
  - Entry matches if valid, entry player < PLAYERS, and codes are equal. With the ext-wildcard bit set, bit [8] is ignored.
  - Every matching entry sets key_state[player][button] = pressed. The scan always runs full depth, so multiple matches all apply.
  - Unmatched codes change nothing.
- Event during SCAN: stored in a 1-deep pending buffer and started on the cycle after the scan ends. An event arriving while the buffer is full is dropped and sets `overflow`. `overflow` clears only on reset.
- `map_wr` in IDLE/SCAN: writes the entry. Under SCAN, an entry written at an index not yet read affects the current scan. Otherwise it affects the next event.
- Merge: src[p][k] = key_state[p][k] | joystick[16p+k], for k=0..7.
- Rotate=1, per player: right←up_src, left←down_src, up←left_src, down←right_src. Other bits pass unchanged.
- `btn` is registered from the merged/remapped value.
- Reset mid-operation: all state is cleared immediately and INIT restarts. Map contents are lost by design.

## Timing
- Reset values: `btn`=0, `overflow`=0, `busy`=1 (INIT), key_state=0, pending empty, coin counters 0.
- INIT: MAP_DEPTH cycles. `busy` falls on the cycle after entry MAP_DEPTH-1 is cleared.
- Toggle edge at cycle t: SCAN starts t+1. Entry i is compared at t+3+i. key_state updates at the end of that cycle. `btn` changes at t+4+i.
- A scan occupies MAP_DEPTH+2 cycles. `busy` stays high across back-to-back pending scans.
- `joystick`/`rotate` to `btn`: 1 cycle.

## Configuration
- `INPUT_MAP_AUTO_COIN_EN` defined:
  - A rising edge of merged start[p] loads a per-player counter with COIN_PULSE. Another rising edge while running reloads it.
  - `btn` coin bit = mapped coin | joystick coin | (counter≠0).
- Undefined: the coin bit is the mapped coin | joystick coin only, and no counters are synthesised.

## Test plan
- Reset, hold 40 cycles, release → `busy`=1 for 32 cycles, then 0; `btn`=0.
- Map entry 5 = {valid, ext-wild, player 0, button 1, code 'h06B}; toggle with pressed=1, code 'h16B → `btn[1]`=1 exactly 9 cycles after the toggle. Toggle again with pressed=0 → `btn[1]`=0.
- Entries 0 and 31 both map code 'h029, to P0 fire and P1 fire; press → `btn[4]` and `btn[12]` set on their respective cycles; `overflow`=0.
- Three toggles 2 cycles apart → first two processed, third dropped, `overflow`=1 and held.
- `rotate`=1, `joystick[3]`=1 (P0 up) → `btn[0]`=1 (right) after 1 cycle. `rotate`=0 → `btn[3]`=1.
- With `INPUT_MAP_AUTO_COIN_EN`, `joystick[6]` rising (P0 start) → `btn[7]` high for exactly 2048 cycles. Without the macro, `btn[7]` stays 0.

Source files
------------

// File: rtl/arcade_input_map.sv
// rtl/arcade_input_map.sv - scancode-map driven PS/2 and joystick to cabinet button mapper
// Optional auto-coin pulse on start press: define INPUT_MAP_AUTO_COIN_EN.
module arcade_input_map #(
    parameter int          PLAYERS    = 2,
    parameter int          MAP_DEPTH  = 32,
    parameter logic [15:0] COIN_PULSE = 16'd2048
) (
    input  logic                         clk_sys,
    input  logic                         reset_n,
    input  logic [10:0]                  ps2_key,
    input  logic [16*PLAYERS-1:0]        joystick,
    input  logic                         rotate,
    input  logic                         map_wr,
    input  logic [$clog2(MAP_DEPTH)-1:0] map_addr,
    input  logic [15:0]                  map_data,
    output logic [8*PLAYERS-1:0]         btn,
    output logic                         busy,
    output logic                         overflow
);
    localparam int AW = $clog2(MAP_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] LAST_RD  = CW'(MAP_DEPTH - 1);
    localparam logic [CW-1:0] SCAN_END = CW'(MAP_DEPTH + 1);

    typedef enum logic [1:0] {S_INIT, S_IDLE, S_SCAN} state_t;
    state_t state, state_nx;

    logic          tog_q;
    logic [CW-1:0] cnt;
    logic [9:0]    cur_ev, pend_ev;
    logic          pend_valid;
    logic          cmp_en;
    logic [15:0]   rd_data;
    logic [15:0]   mem [MAP_DEPTH];
    logic [8*PLAYERS-1:0] key_state, src, btn_nx;
    logic          ev, start_ev, start_pend, store_pend, drop;

    assign ev   = ps2_key[10] ^ tog_q;
    assign busy = (state != S_IDLE);

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) state <= S_INIT;
        else          state <= state_nx;
    end

    // The last scan cycle hands over straight to a pending (or simultaneous) event.
    always_comb begin
        state_nx   = state;
        start_ev   = 1'b0;
        start_pend = 1'b0;
        store_pend = 1'b0;
        drop       = 1'b0;
        case (state)
            S_INIT: if (cnt[AW-1:0] == AW'(MAP_DEPTH - 1)) state_nx = S_IDLE;
            S_IDLE: if (ev) begin
                state_nx = S_SCAN;
                start_ev = 1'b1;
            end
            S_SCAN: begin
                if (cnt == SCAN_END) begin
                    if (pend_valid) begin
                        start_pend = 1'b1;
                        store_pend = ev;
                    end else if (ev) begin
                        start_ev = 1'b1;
                    end else begin
                        state_nx = S_IDLE;
                    end
                end else if (ev) begin
                    if (pend_valid) drop = 1'b1;
                    else            store_pend = 1'b1;
                end
            end
            default: state_nx = S_INIT;
        endcase
    end

    // Map RAM: INIT owns the write port; reads return the pre-write value.
    always_ff @(posedge clk_sys) begin
        if (state == S_INIT)  mem[cnt[AW-1:0]] <= 16'd0;
        else if (map_wr)      mem[map_addr]    <= map_data;
        rd_data <= mem[cnt[AW-1:0]];
    end

    logic [1:0] rd_player;
    logic [2:0] rd_button;
    logic       hit;
    assign rd_player = rd_data[11:10];
    assign rd_button = rd_data[14:12];
    assign hit = cmp_en && rd_data[15] && (int'(rd_player) < PLAYERS)
              && (rd_data[7:0] == cur_ev[7:0])
              && (rd_data[9] || (rd_data[8] == cur_ev[8]));

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            tog_q      <= 1'b0;
            cnt        <= '0;
            cur_ev     <= '0;
            pend_ev    <= '0;
            pend_valid <= 1'b0;
            overflow   <= 1'b0;
            cmp_en     <= 1'b0;
            key_state  <= '0;
            btn        <= '0;
        end else begin
            tog_q <= ps2_key[10];
            if (start_ev || start_pend || state_nx == S_IDLE) cnt <= '0;
            else                                               cnt <= cnt + 1'b1;
            if (start_ev)        cur_ev <= ps2_key[9:0];
            else if (start_pend) cur_ev <= pend_ev;
            if (store_pend) begin
                pend_ev    <= ps2_key[9:0];
                pend_valid <= 1'b1;
            end else if (start_pend) begin
                pend_valid <= 1'b0;
            end
            if (drop) overflow <= 1'b1;
            cmp_en <= (state == S_SCAN) && (cnt <= LAST_RD);
            for (int p = 0; p < PLAYERS; p++)
                for (int k = 0; k < 8; k++)
                    if (hit && rd_player == 2'(p) && rd_button == 3'(k))
                        key_state[8*p+k] <= cur_ev[9];
            btn <= btn_nx;
        end
    end

    always_comb begin
        src = '0;
        for (int p = 0; p < PLAYERS; p++)
            src[8*p +: 8] = key_state[8*p +: 8] | joystick[16*p +: 8];
    end

`ifdef INPUT_MAP_AUTO_COIN_EN
    logic [15:0]        coin_cnt [PLAYERS];
    logic [PLAYERS-1:0] start_q;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            start_q <= '0;
            for (int p = 0; p < PLAYERS; p++) coin_cnt[p] <= 16'd0;
        end else begin
            for (int p = 0; p < PLAYERS; p++) begin
                start_q[p] <= src[8*p+6];
                if (src[8*p+6] && !start_q[p]) coin_cnt[p] <= COIN_PULSE;
                else if (coin_cnt[p] != 16'd0) coin_cnt[p] <= coin_cnt[p] - 16'd1;
            end
        end
    end
`endif

    // Rotated cabinets: right<-up, left<-down, up<-left, down<-right.
    always_comb begin
        btn_nx = '0;
        for (int p = 0; p < PLAYERS; p++) begin
            btn_nx[8*p +: 8] = src[8*p +: 8];
            if (rotate) begin
                btn_nx[8*p+0] = src[8*p+3];
                btn_nx[8*p+1] = src[8*p+2];
                btn_nx[8*p+2] = src[8*p+0];
                btn_nx[8*p+3] = src[8*p+1];
            end
`ifdef INPUT_MAP_AUTO_COIN_EN
            btn_nx[8*p+7] = src[8*p+7] | (coin_cnt[p] != 16'd0);
`endif
        end
    end
endmodule

// File: tb/tb_arcade_input_map.sv
// tb/tb_arcade_input_map.sv - directed bench for arcade_input_map (2 players, 32 entries)
module tb_arcade_input_map;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [10:0] ps2_key = '0;
    logic [31:0] joystick = '0;
    logic        rotate = 1'b0;
    logic        map_wr = 1'b0;
    logic [4:0]  map_addr = '0;
    logic [15:0] map_data = '0;
    logic [15:0] btn;
    logic        busy, overflow;
    int errors = 0;
    int checks = 0;

    arcade_input_map #(.PLAYERS(2), .MAP_DEPTH(32), .COIN_PULSE(16'd2048)) dut (
        .clk_sys(clk), .reset_n(rst_n), .ps2_key(ps2_key), .joystick(joystick),
        .rotate(rotate), .map_wr(map_wr), .map_addr(map_addr), .map_data(map_data),
        .btn(btn), .busy(busy), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic sync();
        @(posedge clk); #1;
    endtask

    task automatic step();
        @(posedge clk); @(negedge clk);
    endtask

    task automatic write_entry(input logic [4:0] a, input logic [15:0] d);
        sync();
        map_wr = 1'b1; map_addr = a; map_data = d;
        sync();
        map_wr = 1'b0;
    endtask

    task automatic send_key(input logic pressed, input logic [8:0] code);
        ps2_key = {~ps2_key[10], pressed, code};
    endtask

    task automatic wait_idle();
        int n = 0;
        repeat (2) @(negedge clk);
        while (busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (busy) begin
            errors++;
            $display("FAIL wait_idle: busy=%0b after %0d cycles, required 0", busy, n);
        end
        sync();
    endtask

    task automatic test_reset();
        int n = 0;
        rst_n = 1'b0;
        repeat (40) @(posedge clk);
        @(negedge clk);
        checks++;
        if (btn !== 16'h0 || busy !== 1'b1 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: btn=%h busy=%b ovf=%b, required 0000 1 0", btn, busy, overflow);
        end
        rst_n = 1'b1;
        #1;
        while (n < 100) begin
            @(posedge clk); n++;
            @(negedge clk);
            if (!busy) break;
        end
        checks++;
        if (n !== 32) begin
            errors++;
            $display("FAIL init_length: busy fell after %0d cycles, required 32", n);
        end
        checks++;
        if (btn !== 16'h0) begin
            errors++;
            $display("FAIL init_btn: btn=%h required 0000", btn);
        end
        sync();
    endtask

    task automatic test_ext_wildcard();
        write_entry(5'd5, 16'h926B);
        write_entry(5'd6, 16'hD475);
        send_key(1'b1, 9'h16B);
        for (int k = 1; k <= 9; k++) begin
            step();
            checks++;
            if (btn[1] !== (k == 9)) begin
                errors++;
                $display("FAIL wild_latency k=%0d: btn[1]=%b required %b", k, btn[1], (k == 9));
            end
        end
        wait_idle();
        checks++;
        if (btn !== 16'h0002) begin
            errors++;
            $display("FAIL wild_press: btn=%h required 0002", btn);
        end
        send_key(1'b0, 9'h16B);
        wait_idle();
        checks++;
        if (btn !== 16'h0000) begin
            errors++;
            $display("FAIL wild_release: btn=%h required 0000", btn);
        end
        send_key(1'b1, 9'h175);
        wait_idle();
        checks++;
        if (btn !== 16'h0000) begin
            errors++;
            $display("FAIL exact_ext_mismatch: btn=%h required 0000", btn);
        end
        send_key(1'b1, 9'h075);
        wait_idle();
        checks++;
        if (btn !== 16'h2000) begin
            errors++;
            $display("FAIL exact_match_p1: btn=%h required 2000", btn);
        end
        send_key(1'b0, 9'h075);
        wait_idle();
        checks++;
        if (btn !== 16'h0000) begin
            errors++;
            $display("FAIL exact_release_p1: btn=%h required 0000", btn);
        end
    endtask

    task automatic test_multi_match();
        write_entry(5'd0, 16'hC029);
        write_entry(5'd31, 16'hC429);
        send_key(1'b1, 9'h029);
        for (int k = 1; k <= 36; k++) begin
            step();
            checks++;
            if (btn[4] !== (k >= 4) || btn[12] !== (k >= 35)) begin
                errors++;
                $display("FAIL multi_timing k=%0d: btn[4]=%b btn[12]=%b required %b %b",
                         k, btn[4], btn[12], (k >= 4), (k >= 35));
            end
        end
        checks++;
        if (overflow !== 1'b0) begin
            errors++;
            $display("FAIL multi_overflow: overflow=%b required 0", overflow);
        end
        wait_idle();
        send_key(1'b0, 9'h029);
        wait_idle();
        checks++;
        if (btn !== 16'h0000) begin
            errors++;
            $display("FAIL multi_release: btn=%h required 0000", btn);
        end
    endtask

    task automatic test_back_to_back();
        send_key(1'b1, 9'h029);
        sync(); sync();
        send_key(1'b0, 9'h029);
        sync(); sync();
        send_key(1'b1, 9'h029);
        for (int k = 5; k <= 80; k++) begin
            step();
            if (k <= 69) begin
                checks++;
                if (busy !== (k <= 68)) begin
                    errors++;
                    $display("FAIL b2b_busy k=%0d: busy=%b required %b", k, busy, (k <= 68));
                end
            end
            if (k == 6 || k == 80) begin
                checks++;
                if (overflow !== 1'b1) begin
                    errors++;
                    $display("FAIL b2b_overflow k=%0d: overflow=%b required 1", k, overflow);
                end
            end
            if (k == 20) begin
                checks++;
                if (btn !== 16'h0010) begin
                    errors++;
                    $display("FAIL b2b_first k=%0d: btn=%h required 0010", k, btn);
                end
            end
            if (k == 50) begin
                checks++;
                if (btn !== 16'h1000) begin
                    errors++;
                    $display("FAIL b2b_mid k=%0d: btn=%h required 1000", k, btn);
                end
            end
            if (k == 80) begin
                checks++;
                if (btn !== 16'h0000) begin
                    errors++;
                    $display("FAIL b2b_third_dropped: btn=%h required 0000", btn);
                end
            end
        end
        sync();
    endtask

    task automatic test_rotate();
        rotate = 1'b1; joystick = 32'h0000_0008;
        step();
        checks++;
        if (btn !== 16'h0001) begin
            errors++;
            $display("FAIL rot_up_to_right: btn=%h required 0001", btn);
        end
        sync();
        rotate = 1'b0;
        step();
        checks++;
        if (btn !== 16'h0008) begin
            errors++;
            $display("FAIL unrot_up: btn=%h required 0008", btn);
        end
        sync();
        rotate = 1'b1; joystick = 32'h0001_0000;
        step();
        checks++;
        if (btn !== 16'h0400) begin
            errors++;
            $display("FAIL rot_p1_right_to_down: btn=%h required 0400", btn);
        end
        sync();
        joystick = 32'h0002_0020;
        step();
        checks++;
        if (btn !== 16'h0820) begin
            errors++;
            $display("FAIL rot_p1_left_fire2: btn=%h required 0820", btn);
        end
        sync();
        rotate = 1'b0; joystick = 32'h0000_0080;
        step();
        checks++;
        if (btn !== 16'h0080) begin
            errors++;
            $display("FAIL joy_coin: btn=%h required 0080", btn);
        end
        sync();
        joystick = '0;
        step();
        sync();
    endtask

    task automatic test_coin();
        int high = 0;
        joystick = 32'h0000_0040;
        step();
        checks++;
        if (btn !== 16'h0040) begin
            errors++;
            $display("FAIL coin_start_first: btn=%h required 0040", btn);
        end
        for (int k = 0; k < 2200; k++) begin
            step();
            if (btn[7]) high++;
        end
`ifdef INPUT_MAP_AUTO_COIN_EN
        checks++;
        if (high !== 2048) begin
            errors++;
            $display("FAIL coin_pulse_len: high=%0d required 2048", high);
        end
`else
        checks++;
        if (high !== 0) begin
            errors++;
            $display("FAIL coin_disabled: high=%0d required 0", high);
        end
`endif
        sync();
        joystick = '0;
        step();
        sync();
    endtask

    task automatic test_reset_mid();
        send_key(1'b1, 9'h029);
        sync(); sync();
        rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if (overflow !== 1'b0 || busy !== 1'b1 || btn !== 16'h0) begin
            errors++;
            $display("FAIL mid_reset: ovf=%b busy=%b btn=%h required 0 1 0000", overflow, busy, btn);
        end
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (34) @(posedge clk);
        #1;
        send_key(1'b1, 9'h029);
        wait_idle();
        checks++;
        if (btn !== 16'h0000) begin
            errors++;
            $display("FAIL map_cleared: btn=%h required 0000", btn);
        end
    endtask

    initial begin
        test_reset();
        test_ext_wildcard();
        test_multi_match();
        test_back_to_back();
        test_rotate();
        test_coin();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
